// File: rtl/imm_operand_pipe.sv
// imm_operand_pipe: decodes RISC-V immediates at push time into a 2-entry FIFO
// whose head entry drives the outputs straight from registers.
module imm_operand_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      in_instr,
    input  logic [2:0]       in_type,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic [7:0]       err_cnt
);
    logic [31:7]      ins;
    logic [XLEN-1:0]  dec_imm, imm0_q, imm0_d, imm1_q, imm1_d;
    logic [TAG_W-1:0] tag0_q, tag0_d, tag1_q, tag1_d;
    logic             err0_q, err0_d, err1_q, err1_d, dec_err, push, pop;
    logic [1:0]       cnt_q, cnt_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    // Index instruction bits by their architectural position [31:7].
    assign ins     = in_instr;
    assign dec_err = in_type == 3'd7;
    assign dec_imm = in_type == 3'd1 ? XLEN'($signed(ins[31:20])) :
                     in_type == 3'd2 ? XLEN'($signed({ins[31:25], ins[11:7]})) :
                     in_type == 3'd3 ? XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0})) :
                     in_type == 3'd4 ? XLEN'($signed({ins[31:12], 12'b0})) :
                     in_type == 3'd5 ? XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0})) :
                     in_type == 3'd6 ? XLEN'(ins[19:15]) : '0;

    assign in_ready  = ~cnt_q[1];
    assign out_valid = |cnt_q;
    assign out_imm   = imm0_q;
    assign out_tag   = tag0_q;
    assign out_err   = err0_q;
    assign err_cnt   = err_cnt_q;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign err_cnt_d = (push && dec_err && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;

    // Head slot is cleared whenever it empties so idle outputs read zero.
    always_comb begin
        cnt_d  = cnt_q;
        imm0_d = imm0_q;
        tag0_d = tag0_q;
        err0_d = err0_q;
        imm1_d = imm1_q;
        tag1_d = tag1_q;
        err1_d = err1_q;
        if (flush) begin
            cnt_d  = 2'd0;
            imm0_d = '0;
            tag0_d = '0;
            err0_d = 1'b0;
        end else if (push && (cnt_q == 2'd0 || pop)) begin
            cnt_d  = 2'd1;
            imm0_d = dec_imm;
            tag0_d = in_tag;
            err0_d = dec_err;
        end else if (push) begin
            cnt_d  = 2'd2;
            imm1_d = dec_imm;
            tag1_d = in_tag;
            err1_d = dec_err;
        end else if (pop) begin
            cnt_d  = cnt_q - 2'd1;
            imm0_d = cnt_q[1] ? imm1_q : '0;
            tag0_d = cnt_q[1] ? tag1_q : '0;
            err0_d = cnt_q[1] & err1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt_q     <= 2'd0;
            imm0_q    <= '0;
            tag0_q    <= '0;
            err0_q    <= 1'b0;
            imm1_q    <= '0;
            tag1_q    <= '0;
            err1_q    <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            cnt_q     <= cnt_d;
            imm0_q    <= imm0_d;
            tag0_q    <= tag0_d;
            err0_q    <= err0_d;
            imm1_q    <= imm1_d;
            tag1_q    <= tag1_d;
            err1_q    <= err1_d;
            err_cnt_q <= err_cnt_d;
        end
endmodule

// File: tb/tb_imm_operand_pipe.sv
// tb_imm_operand_pipe: drives 32- and 64-bit instances with shared stimulus and
// checks them against a queue-based reference model.
module tb_imm_operand_pipe;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [31:0] instr = '0;
    logic [24:0] in_instr;
    logic [2:0]  in_type = '0;
    logic [7:0]  in_tag = '0;
    logic        r32, v32, e32, r64, v64, e64;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [7:0]  t32, t64, ec32, ec64;
    int n_chk = 0, n_fail = 0, merr = 0;

    typedef struct { logic [63:0] imm; logic [7:0] tag; logic err; } ent_t;
    ent_t mq[$];

    assign in_instr = instr[31:7];
    always #5 clk = ~clk;

    imm_operand_pipe #(.XLEN(32), .TAG_W(8)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r32), .in_instr(in_instr),
        .in_type(in_type), .in_tag(in_tag), .flush(flush), .out_valid(v32), .out_ready(out_ready),
        .out_imm(imm32), .out_tag(t32), .out_err(e32), .err_cnt(ec32));
    imm_operand_pipe #(.XLEN(64), .TAG_W(8)) u64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r64), .in_instr(in_instr),
        .in_type(in_type), .in_tag(in_tag), .flush(flush), .out_valid(v64), .out_ready(out_ready),
        .out_imm(imm64), .out_tag(t64), .out_err(e64), .err_cnt(ec64));

    function automatic longint sx(longint v, int n);
        return (v >= (longint'(1) << (n - 1))) ? v - (longint'(1) << n) : v;
    endfunction

    function automatic logic [63:0] ref_imm(bit [31:0] w, logic [2:0] ty);
        longint x = longint'(w);
        case (ty)
            3'd1: return sx(x >> 20, 12);
            3'd2: return sx(((x >> 25) << 5) | ((x >> 7) & 31), 12);
            3'd3: return sx((((x >> 31) & 1) << 12) | (((x >> 7) & 1) << 11) |
                            (((x >> 25) & 63) << 5) | (((x >> 8) & 15) << 1), 13);
            3'd4: return sx(x & 64'hFFFFF000, 32);
            3'd5: return sx((((x >> 31) & 1) << 20) | (x & 64'hFF000) |
                            (((x >> 20) & 1) << 11) | (((x >> 21) & 1023) << 1), 21);
            3'd6: return (x >> 15) & 31;
            default: return 64'd0;
        endcase
    endfunction

    // Advance the reference model by one clock using the inputs currently driven.
    task automatic cycle();
        bit push, pop;
        ent_t e;
        push  = in_valid && mq.size() < 2 && !flush;
        pop   = mq.size() != 0 && out_ready && !flush;
        e.imm = ref_imm(instr, in_type);
        e.tag = in_tag;
        e.err = in_type == 3'd7;
        if (flush) mq.delete();
        else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(e);
        end
        if (push && in_type == 3'd7 && merr < 255) merr++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #3;
        n_chk++; if ({v32, v64, e32, e64} !== 4'b0) begin n_fail++; $display("FAIL reset_valid_err: got %b required 0000", {v32, v64, e32, e64}); end
        n_chk++; if ({imm64, imm32} !== 96'd0) begin n_fail++; $display("FAIL reset_imm: got %h/%h required 0", imm64, imm32); end
        n_chk++; if ({t32, t64, ec32, ec64} !== 32'd0) begin n_fail++; $display("FAIL reset_tag_cnt: got %h required 0", {t32, t64, ec32, ec64}); end
        n_chk++; if ({r32, r64} !== 2'b11) begin n_fail++; $display("FAIL reset_ready: got %b required 11", {r32, r64}); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_decode();
        logic [31:0] w[4] = '{32'hFFF00093, 32'hFFDFF06F, 32'h80000037, 32'h0007D073};
        logic [2:0]  ty[4] = '{3'd1, 3'd5, 3'd4, 3'd6};
        logic [63:0] x64[4] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFF80000000, 64'hF};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            instr = w[i]; in_type = ty[i]; in_tag = 8'(8'h10 + i);
            cycle();
            n_chk++; if (imm64 !== x64[i]) begin n_fail++; $display("FAIL decode64[%0d]: got %h required %h", i, imm64, x64[i]); end
            n_chk++; if (imm32 !== x64[i][31:0] || v32 !== 1'b1) begin n_fail++; $display("FAIL decode32[%0d]: got %h v=%b required %h v=1", i, imm32, v32, x64[i][31:0]); end
            n_chk++; if (t32 !== 8'(8'h10 + i)) begin n_fail++; $display("FAIL decode_tag[%0d]: got %h required %h", i, t32, 8'(8'h10 + i)); end
        end
        in_valid = 1'b0;
        cycle();
        n_chk++; if (v32 !== 1'b0 || imm32 !== 32'd0 || t32 !== 8'd0) begin n_fail++; $display("FAIL decode_drain: got v=%b imm=%h tag=%h required 0", v32, imm32, t32); end
    endtask

    task automatic test_backpressure();
        logic [7:0] want[4] = '{8'd1, 8'd2, 8'd3, 8'd0};
        out_ready = 1'b0; in_valid = 1'b1; in_type = 3'd1; instr = 32'h00100093;
        in_tag = 8'd1; cycle();
        in_tag = 8'd2; cycle();
        n_chk++; if (r32 !== 1'b0) begin n_fail++; $display("FAIL bp_ready_drop: got %b required 0", r32); end
        in_tag = 8'd3;
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_chk++; if (t32 !== 8'd1 || v32 !== 1'b1 || r32 !== 1'b0 || imm32 !== 32'd1) begin n_fail++; $display("FAIL bp_hold[%0d]: got tag=%h v=%b rdy=%b imm=%h required tag=01 v=1 rdy=0 imm=1", i, t32, v32, r32, imm32); end
        end
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            cycle();
            if (i == 2) in_valid = 1'b0;
            n_chk++; if (t32 !== want[i] || v32 !== (i < 3)) begin n_fail++; $display("FAIL bp_order[%0d]: got tag=%h v=%b required tag=%h v=%b", i, t32, v32, want[i], i < 3); end
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1; in_type = 3'd2; instr = 32'hFE000FA3;
        in_tag = 8'h21; cycle();
        in_tag = 8'h22; cycle();
        flush = 1'b1; in_tag = 8'hAA; cycle();
        flush = 1'b0; in_valid = 1'b0;
        n_chk++; if (v32 !== 1'b0 || r32 !== 1'b1 || imm64 !== 64'd0 || t64 !== 8'd0) begin n_fail++; $display("FAIL flush_empty: got v=%b rdy=%b imm=%h tag=%h required v=0 rdy=1 imm=0 tag=0", v32, r32, imm64, t64); end
        out_ready = 1'b1; cycle();
        n_chk++; if (v32 !== 1'b0 || t32 !== 8'd0) begin n_fail++; $display("FAIL flush_no_ghost: got v=%b tag=%h required v=0 tag=00", v32, t32); end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1; in_valid = 1'b1; in_type = 3'd7; instr = 32'hFFFFFFFF;
        for (int i = 0; i < 300; i++) begin
            in_tag = 8'(i);
            cycle();
            n_chk++; if (e32 !== 1'b1 || e64 !== 1'b1 || imm64 !== 64'd0 || imm32 !== 32'd0 || t32 !== 8'(i)) begin n_fail++; $display("FAIL illegal[%0d]: got err=%b imm=%h tag=%h required err=1 imm=0 tag=%h", i, e32, imm64, t32, 8'(i)); end
        end
        in_valid = 1'b0; cycle();
        n_chk++; if (ec32 !== 8'd255 || ec64 !== 8'd255) begin n_fail++; $display("FAIL err_cnt_sat: got %0d/%0d required 255", ec32, ec64); end
        flush = 1'b1; cycle(); flush = 1'b0;
        n_chk++; if (ec32 !== 8'd255) begin n_fail++; $display("FAIL err_cnt_flush: got %0d required 255", ec32); end
    endtask

    task automatic test_reset_midop();
        out_ready = 1'b0; in_valid = 1'b1; in_type = 3'd3; instr = 32'hFE000EE3;
        in_tag = 8'h31; cycle();
        in_tag = 8'h32; cycle();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        n_chk++; if ({v32, v64, e32, e64} !== 4'b0 || imm64 !== 64'd0 || imm32 !== 32'd0 || t32 !== 8'd0 || ec32 !== 8'd0) begin n_fail++; $display("FAIL midop_reset: got v=%b imm=%h tag=%h cnt=%0d required all 0", v32, imm64, t32, ec32); end
        n_chk++; if (r32 !== 1'b1) begin n_fail++; $display("FAIL midop_ready: got %b required 1", r32); end
        @(posedge clk); #1;
        rst_n = 1'b1; mq.delete(); merr = 0;
        in_valid = 1'b1; in_tag = 8'h40; cycle();
        in_valid = 1'b0;
        n_chk++; if (v32 !== 1'b1 || t32 !== 8'h40 || imm64 !== ref_imm(32'hFE000EE3, 3'd3)) begin n_fail++; $display("FAIL midop_push: got v=%b tag=%h imm=%h required v=1 tag=40 imm=%h", v32, t32, imm64, ref_imm(32'hFE000EE3, 3'd3)); end
    endtask

    task automatic test_random();
        ent_t h;
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(3, 0) != 0);
            out_ready = ($urandom_range(2, 0) != 0);
            flush     = ($urandom_range(19, 0) == 0);
            instr     = $urandom;
            in_type   = 3'($urandom_range(7, 0));
            in_tag    = 8'($urandom);
            cycle();
            h = mq.size() != 0 ? mq[0] : '{64'd0, 8'd0, 1'b0};
            n_chk++; if (v32 !== (mq.size() != 0) || v64 !== (mq.size() != 0)) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b/%b required %b", i, v32, v64, mq.size() != 0); end
            n_chk++; if (r32 !== (mq.size() < 2)) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b required %b", i, r32, mq.size() < 2); end
            n_chk++; if (imm64 !== h.imm || imm32 !== h.imm[31:0]) begin n_fail++; $display("FAIL rnd_imm[%0d]: got %h/%h required %h", i, imm64, imm32, h.imm); end
            n_chk++; if (t32 !== h.tag || e32 !== h.err || e64 !== h.err) begin n_fail++; $display("FAIL rnd_tag_err[%0d]: got %h/%b required %h/%b", i, t32, e32, h.tag, h.err); end
            n_chk++; if (ec32 !== 8'(merr)) begin n_fail++; $display("FAIL rnd_err_cnt[%0d]: got %0d required %0d", i, ec32, merr); end
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_backpressure();
        test_flush();
        test_illegal();
        test_reset_midop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/imm_operand_pipe.md
IMM_OPERAND_PIPE -- requirements
Module: imm_operand_pipe

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- XLEN, 32, immediate output width; legal values 32 and 64.
- TAG_W, 8, width of the sideband tag carried with each entry.

REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, the single clock; all state changes on its rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, request present.
- in_ready, out, 1, block can accept a request.
- in_instr, in, 25, instruction bits [31:7].
- in_type, in, 3, immediate format.
- in_tag, in, TAG_W, sideband data passed through unchanged.
- flush, in, 1, synchronous discard of all held entries.
- out_valid, out, 1, head entry present.
- out_ready, in, 1, consumer accepts the head entry.
- out_imm, out, XLEN, decoded immediate.
- out_tag, out, TAG_W, tag of the head entry.
- out_err, out, 1, head entry had an illegal type.
- err_cnt, out, 8, saturating count of accepted illegal-type requests.

Function
REQ-003 Format encodings SHALL be: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z, 7 illegal. In this list, I denotes in_instr indexed by instruction bit number.
REQ-004 R SHALL decode to 0.
REQ-005 I SHALL decode to sext(I[31:20]).
REQ-006 S SHALL decode to sext({I[31:25],I[11:7]}).
REQ-007 B SHALL decode to sext({I[31],I[7],I[30:25],I[11:8],0}).
REQ-008 U SHALL decode to sext({I[31:12],12'b0}).
REQ-009 J SHALL decode to sext({I[31],I[19:12],I[20],I[30:21],0}).
REQ-010 Z (CSR zimm) SHALL decode to zero-extended I[19:15].
REQ-011 Illegal type SHALL decode to 0 with the entry's err flag set to 1.
REQ-012 sext SHALL replicate bit I[31] up to XLEN bits; for XLEN=64, U-type is sign-extended across bits [63:32].
REQ-013 Decode SHALL happen at push time; each stored entry holds {imm, tag, err}.
REQ-014 Storage SHALL be a 2-entry FIFO with count 0..2.
REQ-015 in_ready SHALL equal (count<2) and SHALL NOT depend combinationally on out_ready.
REQ-016 A push SHALL occur when in_valid && in_ready && !flush.
REQ-017 A pop SHALL occur when out_valid && out_ready && !flush.
REQ-018 out_valid SHALL equal (count!=0); out_imm, out_tag and out_err SHALL show the head entry and be driven from registers only.
REQ-019 Latency: a request pushed in cycle N with count=0 SHALL be visible on the outputs in cycle N+1.
REQ-020 Push and pop in the same cycle with count=1 SHALL leave count=1, with the new entry at the head in the next cycle.
REQ-021 With count=2, no push SHALL occur; a pop SHALL move the second entry to the head.
REQ-022 Entries SHALL leave in push order.
REQ-023 While out_valid=1 && out_ready=0, the outputs SHALL hold stable.
REQ-024 While out_valid=0, out_imm, out_tag and out_err SHALL read 0.
REQ-025 flush SHALL set count to 0 in the next cycle, drop any same-cycle input, and take priority over push and pop.
REQ-026 err_cnt SHALL increment on each push with in_type=7 and saturate at 255.
REQ-027 err_cnt SHALL ignore flush and SHALL clear only on reset.

Reset
REQ-028 While rst_n=0, asynchronously: count=0, out_valid=0, out_imm=0, out_tag=0, out_err=0, err_cnt=0; in_ready reads 1.
REQ-029 Reset asserted mid-operation SHALL discard all entries with no partial output.
REQ-030 The first push SHALL be possible on the first rising clk edge after rst_n deasserts.

Verification
REQ-031 I/J decode: XLEN=32, push instr 0xFFF00093 (type I), then 0xFFDFF06F (type J), out_ready=1 -> out_imm 0xFFFFFFFF, then 0xFFFFFFFC, each one cycle after push.
REQ-032 U and Z decode: XLEN=64, push 0x80000037 (type U) -> out_imm 0xFFFFFFFF80000000; push 0x0007D073 (type Z) -> out_imm 0x000000000000000F.
REQ-033 Backpressure: out_ready=0, offer tags 1,2,3 on consecutive cycles -> in_ready drops to 0 after tag 2 and tag 3 is held; raise out_ready -> tags 1,2,3 emerge in order, no loss and no duplication.
REQ-034 Flush: count=2, assert flush together with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed input never appears.
REQ-035 Illegal type: push type 7 300 times -> each entry shows out_err=1 and out_imm=0; err_cnt=255; a subsequent flush leaves err_cnt=255.
REQ-036 Reset mid-operation: drop rst_n to 0 for one cycle with count=2 -> all outputs 0 immediately, without waiting for a clock edge; a push after rst_n rises appears one cycle later.
